// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial value receiver.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam int DEF_DATA_W       = 3;
  localparam int DEF_CLKS_PER_BIT = 16;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for a single asynchronous pin, reset value selectable.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_val_rx.sv
// UART-style receiver: start, DATA_W bits LSB first, stop. Holds the last good
// payload on serial_val and strobes val_valid / frame_err per frame.
module serial_val_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  output logic [DATA_W-1:0] serial_val,
  output logic              val_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int IDX_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

  logic              rx_s;
  rx_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] sreg;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sreg       <= '0;
      serial_val <= '0;
      val_valid  <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      val_valid <= 1'b0;
      frame_err <= 1'b0;
      cnt       <= cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        START: begin
          // Mid-start-bit check: a low shorter than half a bit is a glitch.
          if (cnt == HALF_M1) begin
            cnt <= '0;
            idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt  <= '0;
            sreg <= DATA_W'({rx_s, sreg} >> 1);
            idx  <= idx + IDX_W'(1);
            if (idx == LAST_BIT) state <= STOP;
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              serial_val <= sreg;
              val_valid  <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          // Swallow a stuck-low line so it cannot masquerade as new frames.
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_val_rx.sv
// Self-checking bench for serial_val_rx: frame-level model predicts strobe cycles and values.
module tb_serial_val_rx;

  localparam int DATA_W = 3;
  localparam int CPB    = 16;
  localparam int H      = CPB / 2;
  localparam int LAT    = 2 + H + (DATA_W + 1) * CPB;
  localparam int HIST   = 8192;

  typedef struct packed {
    logic [31:0]       cyc;
    logic              vv;
    logic              fe;
    logic [DATA_W-1:0] val;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_in = 1'b1;
  logic [DATA_W-1:0] serial_val;
  logic              val_valid, frame_err, busy;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic busy_hist [HIST];
  ev_t  ev[$];
  ev_t  exp_q[$];
  logic [DATA_W-1:0] model_val;

  serial_val_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .serial_val (serial_val),
    .val_valid  (val_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cyc < HIST) busy_hist[cyc] = busy;
    if (val_valid || frame_err) ev.push_back('{cyc: 32'(cyc), vv: val_valid, fe: frame_err, val: serial_val});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Drives one frame; returns the cycle number of E0.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop, output int e0);
    rx_in = 1'b0;
    e0 = cyc + 1;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < DATA_W; i++) begin
      rx_in = d[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_in = stop;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level reference: a good stop publishes the payload, a bad one keeps the old word.
  task automatic model_frame(input int e0, input logic [DATA_W-1:0] d, input logic stop);
    if (stop) begin
      model_val = d;
      exp_q.push_back('{cyc: 32'(e0 + LAT), vv: 1'b1, fe: 1'b0, val: d});
    end else begin
      exp_q.push_back('{cyc: 32'(e0 + LAT), vv: 1'b0, fe: 1'b1, val: model_val});
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (serial_val !== '0) begin n_fail++; $display("FAIL reset_serial_val: got %0d want 0", serial_val); end
    n_chk++; if (val_valid !== 1'b0) begin n_fail++; $display("FAIL reset_val_valid: got %b want 0", val_valid); end
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    model_val = '0;
    rst_n = 1'b1;
    idle(20);
  endtask

  task automatic test_single;
    int e0;
    ev.delete(); exp_q.delete();
    send_frame(3'd5, 1'b1, e0);
    model_frame(e0, 3'd5, 1'b1);
    idle(10);
    n_chk++; if (ev.size() != exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d want %0d", ev.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev.size(); i++) begin
      n_chk++;
      if (ev[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_ev%0d: got cyc=%0d vv=%b fe=%b val=%0d want cyc=%0d vv=%b fe=%b val=%0d", i, ev[i].cyc, ev[i].vv, ev[i].fe, ev[i].val, exp_q[i].cyc, exp_q[i].vv, exp_q[i].fe, exp_q[i].val); end
    end
    n_chk++; if (busy_hist[e0+1] !== 1'b0) begin n_fail++; $display("FAIL single_busy_e1: got %b want 0", busy_hist[e0+1]); end
    n_chk++; if (busy_hist[e0+2] !== 1'b1) begin n_fail++; $display("FAIL single_busy_e2: got %b want 1", busy_hist[e0+2]); end
    n_chk++; if (busy_hist[e0+LAT-1] !== 1'b1) begin n_fail++; $display("FAIL single_busy_end: got %b want 1", busy_hist[e0+LAT-1]); end
    n_chk++; if (busy_hist[e0+LAT] !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b want 0", busy_hist[e0+LAT]); end
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] vals [5] = '{3'd0, 3'd3, 3'd5, 3'd7, 3'd1};
    int e0;
    ev.delete(); exp_q.delete();
    foreach (vals[k]) begin
      send_frame(vals[k], 1'b1, e0);
      model_frame(e0, vals[k], 1'b1);
    end
    idle(10);
    n_chk++; if (ev.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", ev.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev.size(); i++) begin
      n_chk++;
      if (ev[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_ev%0d: got cyc=%0d vv=%b fe=%b val=%0d want cyc=%0d vv=%b fe=%b val=%0d", i, ev[i].cyc, ev[i].vv, ev[i].fe, ev[i].val, exp_q[i].cyc, exp_q[i].vv, exp_q[i].fe, exp_q[i].val); end
    end
  endtask

  task automatic test_bad_stop;
    int e0, e1;
    ev.delete(); exp_q.delete();
    send_frame(3'd6, 1'b0, e0);
    model_frame(e0, 3'd6, 1'b0);
    rx_in = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    idle(20);
    n_chk++; if (busy_hist[e0+LAT+100] !== 1'b1) begin n_fail++; $display("FAIL badstop_busy_low: got %b want 1", busy_hist[e0+LAT+100]); end
    n_chk++; if (busy_hist[e0+200] !== 1'b0) begin n_fail++; $display("FAIL badstop_busy_release: got %b want 0", busy_hist[e0+200]); end
    send_frame(3'd2, 1'b1, e1);
    model_frame(e1, 3'd2, 1'b1);
    idle(10);
    n_chk++; if (ev.size() != exp_q.size()) begin n_fail++; $display("FAIL badstop_count: got %0d want %0d", ev.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev.size(); i++) begin
      n_chk++;
      if (ev[i] !== exp_q[i]) begin n_fail++; $display("FAIL badstop_ev%0d: got cyc=%0d vv=%b fe=%b val=%0d want cyc=%0d vv=%b fe=%b val=%0d", i, ev[i].cyc, ev[i].vv, ev[i].fe, ev[i].val, exp_q[i].cyc, exp_q[i].vv, exp_q[i].fe, exp_q[i].val); end
    end
  endtask

  task automatic test_glitch;
    int len, e0, nbusy;
    for (int g = 0; g < 4; g++) begin
      ev.delete();
      len = (g == 0) ? 3 : int'($urandom_range(1, H - 1));
      e0 = cyc + 1;
      rx_in = 1'b0;
      repeat (len) @(posedge clk);
      #1;
      idle(30);
      nbusy = 0;
      for (int c = e0; c < e0 + 30; c++) if (busy_hist[c] === 1'b1) nbusy++;
      n_chk++; if (nbusy < 1 || nbusy > 10) begin n_fail++; $display("FAIL glitch%0d_busy: got %0d cycles want 1..10 (len %0d)", g, nbusy, len); end
      n_chk++; if (ev.size() != 0) begin n_fail++; $display("FAIL glitch%0d_strobe: got %0d strobes want 0", g, ev.size()); end
      n_chk++; if (serial_val !== model_val) begin n_fail++; $display("FAIL glitch%0d_val: got %0d want %0d", g, serial_val, model_val); end
    end
  endtask

  task automatic test_reset_mid;
    int e0;
    ev.delete(); exp_q.delete();
    rx_in = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (CPB + 5) @(posedge clk);
    #1;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (serial_val !== '0) begin n_fail++; $display("FAIL rstmid_serial_val: got %0d want 0", serial_val); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_chk++; if (val_valid !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_strobes: got %b%b want 00", val_valid, frame_err); end
    repeat (CPB - 5 + 2 * CPB) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_val = '0;
    idle(20);
    send_frame(3'd4, 1'b1, e0);
    model_frame(e0, 3'd4, 1'b1);
    idle(10);
    n_chk++; if (ev.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_count: got %0d want %0d", ev.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev.size(); i++) begin
      n_chk++;
      if (ev[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_ev%0d: got cyc=%0d vv=%b fe=%b val=%0d want cyc=%0d vv=%b fe=%b val=%0d", i, ev[i].cyc, ev[i].vv, ev[i].fe, ev[i].val, exp_q[i].cyc, exp_q[i].vv, exp_q[i].fe, exp_q[i].val); end
    end
  endtask

  task automatic test_random_frames;
    int e0;
    logic [DATA_W-1:0] d;
    logic stop;
    ev.delete(); exp_q.delete();
    for (int f = 0; f < 10; f++) begin
      d = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, stop, e0);
      model_frame(e0, d, stop);
      if (stop) idle(int'($urandom_range(0, 20)));
      else idle(CPB + int'($urandom_range(0, 10)));
    end
    idle(10);
    n_chk++; if (ev.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", ev.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev.size(); i++) begin
      n_chk++;
      if (ev[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_ev%0d: got cyc=%0d vv=%b fe=%b val=%0d want cyc=%0d vv=%b fe=%b val=%0d", i, ev[i].cyc, ev[i].vv, ev[i].fe, ev[i].val, exp_q[i].cyc, exp_q[i].vv, exp_q[i].fe, exp_q[i].val); end
    end
    n_chk++; if (serial_val !== model_val) begin n_fail++; $display("FAIL rand_final_val: got %0d want %0d", serial_val, model_val); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_stop();
    test_glitch();
    test_reset_mid();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
